// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency memory between the
// fetch port and the data port, with per-port done pulses and stalls.
module unified_mem_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        ERR
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              en_q, en_nxt;
    logic              we_q, we_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_nxt;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_nxt;
    logic              if_done_q, if_done_nxt;
    logic              d_done_q, d_done_nxt;
    logic              if_err_q, if_err_nxt;
    logic              d_err_q, d_err_nxt;
    logic              grant_d;
    logic              grant_i;

    // A port finishing this cycle sits out arbitration; data beats fetch.
    assign grant_d = d_req & ~d_done_q;
    assign grant_i = if_req & ~if_done_q & ~grant_d;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_err_q   <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            en_q       <= en_nxt;
            we_q       <= we_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            if_rdata_q <= if_rdata_nxt;
            d_rdata_q  <= d_rdata_nxt;
            if_done_q  <= if_done_nxt;
            d_done_q   <= d_done_nxt;
            if_err_q   <= if_err_nxt;
            d_err_q    <= d_err_nxt;
        end
    end

    // Next-state: grant in IDLE, count down in BUSY, flag errors.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        en_nxt       = 1'b0;
        we_nxt       = we_q;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;
        if_rdata_nxt = '0;
        d_rdata_nxt  = '0;
        if_done_nxt  = 1'b0;
        d_done_nxt   = 1'b0;
        if_err_nxt   = 1'b0;
        d_err_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    if (d_addr[1:0] != 2'b00) begin
                        state_nxt  = ERR;
                        d_done_nxt = 1'b1;
                        d_err_nxt  = 1'b1;
                    end else begin
                        state_nxt = BUSY_D;
                        cnt_nxt   = CNT_W'(MEM_LAT);
                        en_nxt    = 1'b1;
                        we_nxt    = d_we;
                        addr_nxt  = {d_addr[ADDR_W-1:2], 2'b00};
                        wdata_nxt = d_wdata;
                    end
                end else if (grant_i) begin
                    if (if_addr[1:0] != 2'b00) begin
                        state_nxt   = ERR;
                        if_done_nxt = 1'b1;
                        if_err_nxt  = 1'b1;
                    end else begin
                        state_nxt = BUSY_I;
                        cnt_nxt   = CNT_W'(MEM_LAT);
                        en_nxt    = 1'b1;
                        we_nxt    = 1'b0;
                        addr_nxt  = {if_addr[ADDR_W-1:2], 2'b00};
                        wdata_nxt = '0;
                    end
                end
            end
            BUSY_I: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt    = IDLE;
                    if_rdata_nxt = mem_rdata;
                    if_done_nxt  = 1'b1;
                end
            end
            BUSY_D: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt   = IDLE;
                    d_rdata_nxt = we_q ? '0 : mem_rdata;
                    d_done_nxt  = 1'b1;
                end
            end
            ERR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are masked during reset so a pending write never issues.
    assign mem_en    = en_q & ~rst;
    assign mem_we    = en_q & we_q & ~rst;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign if_err    = if_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign d_err     = d_err_q;

    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = d_req & ~d_done_q;

endmodule
